// File: rtl/reg_file_pkg.sv
// Shared constants and address-width helper for the register file slice.
package reg_file_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 16;

    // Address width for a given register count; never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? 32'($clog2(depth)) : 32'd1;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Write, reservation and dual read-port bundle for reg_file.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
);

    localparam int unsigned AW = addr_width(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr_a;
    logic [WIDTH-1:0] rd_data_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_b;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic             busy_a;
    logic             busy_b;
    logic [DEPTH-1:0] busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr,
        input  rd_data_a, rd_data_b, busy_a, busy_b, busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr,
        output rd_data_a, rd_data_b, busy_a, busy_b, busy_vec
    );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port: register select, write bypass and pending flag.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = addr_width(DEPTH)
) (
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] regs_i [DEPTH],
    input  logic [DEPTH-1:0] busy_i,
    input  logic [DEPTH-1:0] wr_hit_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_c_o,
    output logic             busy_c_o
);

    // Unmatched addresses (out of range or hardwired zero) fall through to 0.
    always_comb begin
        rd_data_c_o = '0;
        busy_c_o    = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG && i == 0) && addr_i == AW'(i)) begin
                rd_data_c_o = wr_hit_i[i] ? wr_data_i : regs_i[i];
                busy_c_o    = busy_i[i] && !wr_hit_i[i];
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// Parameterised register file with two bypassed read ports and a pending-write scoreboard.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic       clk,
    input logic       clr,
    reg_file_if.slave bus
);

    localparam int unsigned AW = addr_width(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] wr_hit_c;
    logic [DEPTH-1:0] rsv_hit_c;

    // One-hot decode; out-of-range and hardwired-zero entries never match.
    always_comb begin
        wr_hit_c  = '0;
        rsv_hit_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG && i == 0)) begin
                wr_hit_c[i]  = bus.wr_en  && (bus.wr_addr  == AW'(i));
                rsv_hit_c[i] = bus.rsv_en && (bus.rsv_addr == AW'(i));
            end
        end
    end

    // A reservation in the same cycle as the write to that entry leaves it pending.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_hit_c[i]) begin
                regs_d[i] = bus.wr_data;
                busy_d[i] = 1'b0;
            end
            if (rsv_hit_c[i]) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    reg_file_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_rd_a (
        .addr_i      (bus.rd_addr_a),
        .regs_i      (regs_q),
        .busy_i      (busy_q),
        .wr_hit_i    (wr_hit_c),
        .wr_data_i   (bus.wr_data),
        .rd_data_c_o (bus.rd_data_a),
        .busy_c_o    (bus.busy_a)
    );

    reg_file_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_rd_b (
        .addr_i      (bus.rd_addr_b),
        .regs_i      (regs_q),
        .busy_i      (busy_q),
        .wr_hit_i    (wr_hit_c),
        .wr_data_i   (bus.wr_data),
        .rd_data_c_o (bus.rd_data_b),
        .busy_c_o    (bus.busy_b)
    );

    assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed table-driven bench for reg_file: 32x16 main instance plus an 8x12 instance for range checks.
module tb_reg_file;

    logic clk = 1'b0;
    logic clr32;
    logic clr8;

    always #5 clk = ~clk;

    reg_file_if #(.WIDTH(32), .DEPTH(16)) bus32 ();
    reg_file_if #(.WIDTH(8),  .DEPTH(12)) bus8 ();

    reg_file #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1'b1)) u_dut32 (
        .clk (clk),
        .clr (clr32),
        .bus (bus32.slave)
    );

    reg_file #(.WIDTH(8), .DEPTH(12), .ZERO_REG(1'b1)) u_dut8 (
        .clk (clk),
        .clr (clr8),
        .bus (bus8.slave)
    );

    typedef struct {
        logic        clr;
        logic        wr_en;
        logic [3:0]  wr_addr;
        logic [31:0] wr_data;
        logic        rsv_en;
        logic [3:0]  rsv_addr;
        logic [3:0]  rd_a;
        logic [3:0]  rd_b;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_busy_a;
        logic        exp_busy_b;
        logic [15:0] exp_vec;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input int c, input int we, input int wa, input logic [31:0] wd,
                                input int re, input int ra, input int a, input int b,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input int eba, input int ebb, input int ev);
        vec_t v;
        v.clr        = 1'(c);
        v.wr_en      = 1'(we);
        v.wr_addr    = 4'(wa);
        v.wr_data    = wd;
        v.rsv_en     = 1'(re);
        v.rsv_addr   = 4'(ra);
        v.rd_a       = 4'(a);
        v.rd_b       = 4'(b);
        v.exp_a      = ea;
        v.exp_b      = eb;
        v.exp_busy_a = 1'(eba);
        v.exp_busy_b = 1'(ebb);
        v.exp_vec    = 16'(ev);
        vq.push_back(v);
    endfunction

    task automatic drive32(input vec_t v);
        clr32           = v.clr;
        bus32.wr_en     = v.wr_en;
        bus32.wr_addr   = v.wr_addr;
        bus32.wr_data   = v.wr_data;
        bus32.rsv_en    = v.rsv_en;
        bus32.rsv_addr  = v.rsv_addr;
        bus32.rd_addr_a = v.rd_a;
        bus32.rd_addr_b = v.rd_b;
    endtask

    task automatic drive8(input int c, input int we, input int wa, input int wd,
                          input int re, input int ra, input int a, input int b);
        clr8           = 1'(c);
        bus8.wr_en     = 1'(we);
        bus8.wr_addr   = 4'(wa);
        bus8.wr_data   = 8'(wd);
        bus8.rsv_en    = 1'(re);
        bus8.rsv_addr  = 4'(ra);
        bus8.rd_addr_a = 4'(a);
        bus8.rd_addr_b = 4'(b);
    endtask

    initial begin
        vec_t idle;
        idle = '{clr: 1'b1, wr_en: 1'b0, wr_addr: 4'd0, wr_data: 32'h0, rsv_en: 1'b0,
                 rsv_addr: 4'd0, rd_a: 4'd0, rd_b: 4'd0, exp_a: 32'h0, exp_b: 32'h0,
                 exp_busy_a: 1'b0, exp_busy_b: 1'b0, exp_vec: 16'h0};
        drive32(idle);
        drive8(1, 0, 0, 0, 0, 0, 0, 0);

        //  clr we wa wd            re ra a  b   exp_a         exp_b         ba bb vec
        add(0, 1, 1,  32'h11111111, 1, 2, 1, 2,  32'h11111111, 32'h0,        0, 0, 16'h0000);
        add(0, 1, 4,  32'h00000044, 0, 0, 1, 4,  32'h11111111, 32'h44,       0, 0, 16'h0004);
        add(1, 1, 1,  32'h00000099, 1, 6, 1, 2,  32'h99,       32'h0,        0, 1, 16'h0004);
        add(0, 0, 0,  32'h0,        0, 0, 1, 4,  32'h0,        32'h0,        0, 0, 16'h0000);
        add(0, 1, 5,  32'hDEADBEEF, 0, 0, 5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 16'h0000);
        add(0, 0, 0,  32'h0,        0, 0, 5, 0,  32'hDEADBEEF, 32'h0,        0, 0, 16'h0000);
        add(0, 1, 0,  32'h12345678, 1, 0, 0, 0,  32'h0,        32'h0,        0, 0, 16'h0000);
        add(0, 0, 0,  32'h0,        0, 0, 0, 5,  32'h0,        32'hDEADBEEF, 0, 0, 16'h0000);
        add(0, 0, 0,  32'h0,        1, 3, 3, 3,  32'h0,        32'h0,        0, 0, 16'h0000);
        add(0, 0, 0,  32'h0,        0, 0, 3, 5,  32'h0,        32'hDEADBEEF, 1, 0, 16'h0008);
        add(0, 1, 3,  32'h00000055, 0, 0, 3, 3,  32'h55,       32'h55,       0, 0, 16'h0008);
        add(0, 0, 0,  32'h0,        0, 0, 3, 3,  32'h55,       32'h55,       0, 0, 16'h0000);
        add(0, 1, 7,  32'h000000A5, 1, 7, 7, 7,  32'hA5,       32'hA5,       0, 0, 16'h0000);
        add(0, 0, 0,  32'h0,        0, 0, 7, 3,  32'hA5,       32'h55,       1, 0, 16'h0080);
        add(0, 0, 0,  32'h0,        1, 7, 7, 7,  32'hA5,       32'hA5,       1, 1, 16'h0080);
        add(0, 0, 0,  32'h0,        0, 0, 7, 7,  32'hA5,       32'hA5,       1, 1, 16'h0080);
        add(0, 1, 9,  32'h00000099, 0, 0, 9, 7,  32'h99,       32'hA5,       0, 1, 16'h0080);
        add(1, 1, 7,  32'h00000077, 0, 0, 7, 9,  32'h77,       32'h99,       0, 0, 16'h0080);
        add(0, 0, 0,  32'h0,        0, 0, 7, 9,  32'h0,        32'h0,        0, 0, 16'h0000);
        add(0, 0, 0,  32'h0,        1, 15, 15, 1, 32'h0,       32'h0,        0, 0, 16'h0000);
        add(0, 0, 0,  32'h0,        0, 0, 15, 15, 32'h0,       32'h0,        1, 1, 16'h8000);
        add(0, 1, 15, 32'hCAFE0000, 0, 0, 15, 15, 32'hCAFE0000, 32'hCAFE0000, 0, 0, 16'h8000);
        add(0, 0, 0,  32'h0,        0, 0, 15, 15, 32'hCAFE0000, 32'hCAFE0000, 0, 0, 16'h0000);

        repeat (2) @(posedge clk);

        // Reset state, sampled while clr is still asserted.
        @(negedge clk);
        #1;
        check("reset.rd_a", bus32.rd_data_a, 32'h0);
        check("reset.busy_vec", 32'(bus32.busy_vec), 32'h0);
        check("reset8.busy_vec", 32'(bus8.busy_vec), 32'h0);

        foreach (vq[i]) begin
            @(negedge clk);
            drive32(vq[i]);
            #1;
            check($sformatf("v%0d.rd_a", i), bus32.rd_data_a, vq[i].exp_a);
            check($sformatf("v%0d.rd_b", i), bus32.rd_data_b, vq[i].exp_b);
            check($sformatf("v%0d.busy_a", i), 32'(bus32.busy_a), 32'(vq[i].exp_busy_a));
            check($sformatf("v%0d.busy_b", i), 32'(bus32.busy_b), 32'(vq[i].exp_busy_b));
            check($sformatf("v%0d.busy_vec", i), 32'(bus32.busy_vec), 32'(vq[i].exp_vec));
        end

        // Narrow instance: addresses 12..15 lie beyond DEPTH and must be inert.
        @(negedge clk);
        drive8(0, 1, 13, 8'hAB, 1, 13, 13, 12);
        #1;
        check("d8.oob_bypass_a", 32'(bus8.rd_data_a), 32'h0);
        check("d8.oob_busy_a", 32'(bus8.busy_a), 32'h0);

        @(negedge clk);
        drive8(0, 1, 11, 8'h5A, 1, 12, 13, 13);
        #1;
        check("d8.oob_read_a", 32'(bus8.rd_data_a), 32'h0);
        check("d8.oob_read_b", 32'(bus8.rd_data_b), 32'h0);
        check("d8.oob_busy_vec", 32'(bus8.busy_vec), 32'h0);

        @(negedge clk);
        drive8(0, 1, 12, 8'h3C, 0, 0, 11, 11);
        #1;
        check("d8.r11_a", 32'(bus8.rd_data_a), 32'h5A);
        check("d8.r11_b", 32'(bus8.rd_data_b), 32'h5A);
        check("d8.rsv12_busy_vec", 32'(bus8.busy_vec), 32'h0);

        @(negedge clk);
        drive8(0, 1, 10, 8'hC3, 0, 0, 12, 10);
        #1;
        check("d8.r12_a", 32'(bus8.rd_data_a), 32'h0);
        check("d8.r12_busy_a", 32'(bus8.busy_a), 32'h0);
        check("d8.r10_bypass_b", 32'(bus8.rd_data_b), 32'hC3);

        @(negedge clk);
        drive8(0, 0, 0, 0, 0, 0, 10, 11);
        #1;
        check("d8.r10_a", 32'(bus8.rd_data_a), 32'hC3);
        check("d8.r11_b_hold", 32'(bus8.rd_data_b), 32'h5A);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The module SHALL have a parameter WIDTH, default 32, giving the data width of every register.
REQ-002 The module SHALL have a parameter DEPTH, default 16, giving the number of registers (minimum 2).
REQ-003 The module SHALL have a parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 The module SHALL have a localparam AW = clog2(DEPTH), giving the address width.
REQ-005 The module SHALL use one clock and a synchronous, active-high reset named clr.
REQ-006 Ports:
- clk  in  1  clock; all state changes on its rising edge.
- clr  in  1  synchronous active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rd_addr_a  in  AW  read port A address.
- rd_data_a  out  WIDTH  read port A data.
- rd_addr_b  in  AW  read port B address.
- rd_data_b  out  WIDTH  read port B data.
- rsv_en  in  1  reservation strobe; marks the destination as pending.
- rsv_addr  in  AW  reservation address.
- busy_a  out  1  register at rd_addr_a is pending.
- busy_b  out  1  register at rd_addr_b is pending.
- busy_vec  out  DEPTH  pending bit per register.

Function
REQ-007 Writes SHALL take effect on the rising edge of clk when wr_en=1 and clr=0; regs[wr_addr] <= wr_data.
REQ-008 Reads SHALL be combinational: rd_data_x = regs[rd_addr_x], with zero cycles of latency.
REQ-009 Write bypass: when wr_en=1 and wr_addr==rd_addr_x (and the write is legal), rd_data_x SHALL equal wr_data in the same cycle.
REQ-010 With ZERO_REG=1:
- writes to address 0 SHALL be ignored;
- reads of address 0 SHALL return 0, with no bypass;
- reservations of address 0 SHALL be ignored;
- busy_vec[0] SHALL stay 0.
REQ-011 When DEPTH < 2**AW, writes and reservations to addresses >= DEPTH SHALL be ignored, and reads of those addresses SHALL return 0 with busy 0.
REQ-012 Scoreboard:
- rsv_en=1 SHALL set busy[rsv_addr] at the next edge.
- wr_en=1 SHALL clear busy[wr_addr] at the next edge.
REQ-013 When rsv_en and wr_en target the same address in the same cycle, busy SHALL end set (the new reservation wins) and the data SHALL be written.
REQ-014 Reserving an already-busy register SHALL leave it busy; a write to a non-busy register SHALL be permitted and SHALL leave it non-busy.
REQ-015 Busy outputs: busy_x = busy[rd_addr_x] AND NOT(a legal write to rd_addr_x this cycle), so that they stay consistent with the bypass.
REQ-016 busy_vec SHALL equal the registered busy bits, with no bypass.
REQ-017 rd_addr_a and rd_addr_b SHALL be independent and MAY be equal; both ports SHALL return identical values in that case.

Reset
REQ-018 clr=1 at a rising edge SHALL set every register to 0 and every busy bit to 0, overriding wr_en and rsv_en in that cycle.
REQ-019 While clr=1, read outputs SHALL still follow REQ-008 to REQ-010, including the bypass.
REQ-020 Registers and busy bits SHALL power up at 0 (initial value) to match the post-reset state.

Structure
REQ-021 A shared package SHALL hold the default WIDTH and DEPTH constants and an AW helper function; no typedefs are required.
REQ-022 A single sub-module, reg_file_read_port (one address in, one data out, one busy out, bypass logic), SHALL be instantiated twice, once for port A and once for port B.
REQ-023 Storage SHALL be a flat array of WIDTH-bit registers; no vendor RAM primitives SHALL be used.

Verification
REQ-024 Reset: apply clr=1 for 1 cycle after arbitrary writes -> all reads return 0x00000000 and busy_vec=0x0000.
REQ-025 Write/read plus bypass: write R5=0xDEADBEEF, read R5 on port A in the same cycle -> rd_data_a=0xDEADBEEF in that cycle and in the next cycle.
REQ-026 Zero register: write R0=0x12345678 with rsv_en on R0 -> rd_data_a(R0)=0 and busy_vec[0]=0 after the edge.
REQ-027 Scoreboard:
- reserve R3 -> busy_vec=0x0008 next cycle;
- write R3=0x55 -> during that cycle busy_a(R3)=0 and rd_data_a=0x55;
- afterwards busy_vec=0x0000.
REQ-028 Simultaneous events: rsv_en and wr_en both on R7 (data 0xA5) -> R7 reads 0xA5 next cycle and busy_vec[7]=1; clr asserted in the same cycle as a write -> R7 reads 0 and busy_vec=0.
REQ-029 Parameter sweep: run with WIDTH=8 and DEPTH=12 -> a write to address 13 is ignored, a read of address 13 returns 0x00, and a dual-port read of R11 on both ports matches.
